// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C codec-configuration target.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AACK,
    S_DATA,
    S_DACK,
    S_WAIT
  } i2c_state_e;

  localparam logic [6:0] I2C_CODEC_ADDR   = 7'h1A;
  localparam int         FRAME_DATA_BYTES = 2;

  function automatic logic [7:0] addr_wr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

  localparam logic [7:0] I2C_ADDR_BYTE_W = addr_wr_byte(I2C_CODEC_ADDR);

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into i_clk and decodes SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s;

  // Flops reset to the idle-bus level so leaving reset on an idle bus creates no events.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign o_sda      = sda_sync_q[SYNC_STAGES-1];
  assign o_scl_rise = scl_s & ~scl_hist_q;
  assign o_scl_fall = ~scl_s & scl_hist_q;
  assign o_start    = scl_s & scl_hist_q & sda_hist_q & ~o_sda;
  assign o_stop     = scl_s & scl_hist_q & ~sda_hist_q & o_sda;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: address match, ACK of two data bytes, 16-bit word output.
// Optional I2C_TARGET_ERRCNT_EN adds a saturating protocol-error counter o_err_cnt.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = I2C_CODEC_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl,
  inout  wire         io_sda,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_err
`ifdef I2C_TARGET_ERRCNT_EN
  ,
  output logic [7:0]  o_err_cnt
`endif
);

  localparam logic [7:0] ADDR_BYTE = addr_wr_byte(ADDR);
  localparam logic [1:0] LAST_BYTE = 2'(FRAME_DATA_BYTES - 1);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_scl     (i_scl),
    .i_sda     (io_sda),
    .o_sda     (sda_s),
    .o_scl_rise(scl_rise),
    .o_scl_fall(scl_fall),
    .o_start   (start),
    .o_stop    (stop)
  );

  i2c_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [15:0] data_q, data_d;
  logic        sda_oe_q, sda_oe_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        done_q, done_d;   // word delivered in this frame
  logic        over_q, over_d;   // watching for an unwanted extra data byte
  logic [7:0]  byte_w;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte1_q   <= '0;
      dcnt_q    <= '0;
      data_q    <= '0;
      sda_oe_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte1_q   <= byte1_d;
      dcnt_q    <= dcnt_d;
      data_q    <= data_d;
      sda_oe_q  <= sda_oe_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      done_q    <= done_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path through this block can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte1_d   = byte1_q;
    dcnt_d    = dcnt_q;
    data_d    = data_q;
    sda_oe_d  = sda_oe_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = 1'b0;
    done_d    = done_q;
    over_d    = over_q;
    byte_w    = {shift_q[6:0], sda_s};

    if (start) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      shift_d   = '0;
      dcnt_d    = '0;
      sda_oe_d  = 1'b0;
      err_d     = busy_q & ~done_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      over_d    = 1'b0;
    end else if (stop) begin
      err_d     = (state_q inside {S_ADDR, S_AACK, S_DATA, S_DACK}) && !done_q;
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      dcnt_d    = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      over_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_w == ADDR_BYTE) begin
              state_d = S_AACK;
              busy_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_DATA: if (scl_rise) begin
          shift_d   = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_DACK;
            if (dcnt_q == LAST_BYTE) begin
              data_d  = {byte1_q, byte_w};
              valid_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              byte1_d = byte_w;
              dcnt_d  = dcnt_q + 2'd1;
            end
          end
        end
        // First fall after the 8th bit pulls SDA low; the fall ending the ACK clock releases it.
        S_AACK, S_DACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            if (state_q == S_DACK && done_q) begin
              state_d = S_WAIT;
              busy_d  = 1'b0;
              over_d  = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_WAIT: if (over_q && scl_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            err_d  = 1'b1;
            over_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (state_d == S_IDLE || state_d == S_WAIT) busy_d = 1'b0;
  end

  assign io_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

`ifdef I2C_TARGET_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_cnt_q <= '0;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench: bit-banged I2C controller on a pulled-up wired-AND SDA line.
module tb_i2c_target_rx;

  localparam int H = 8;  // i_clk cycles per SCL phase

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        m_scl, m_sda;
  wire         sda_bus;
  logic [15:0] o_data;
  logic        o_valid, o_busy, o_err;
`ifdef I2C_TARGET_ERRCNT_EN
  logic [7:0]  o_err_cnt;
`endif

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #5 i_clk = ~i_clk;

  i2c_target_rx dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_scl  (m_scl),
    .io_sda (sda_bus),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_busy (o_busy),
    .o_err  (o_err)
`ifdef I2C_TARGET_ERRCNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0, err_cnt = 0, pull_cnt = 0;
  int v0, e0, p0;
  logic ack;

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) valid_cnt++;
    if (o_err === 1'b1) err_cnt++;
    if (m_sda === 1'b1 && sda_bus === 1'b0) pull_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_h(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_h(H);
    m_scl = 1'b1; wait_h(H);
    m_sda = 1'b0; wait_h(H);
    m_scl = 1'b0; wait_h(H);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_h(H);
    m_scl = 1'b1; wait_h(H);
    m_sda = 1'b1; wait_h(4 * H);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_h(H);
    m_scl = 1'b1; wait_h(H);
    m_scl = 1'b0; wait_h(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_h(H);
    m_scl = 1'b1; wait_h(H / 2);
    acked = (sda_bus === 1'b0);
    wait_h(H / 2);
    m_scl = 1'b0; wait_h(H);
  endtask

  task automatic snap();
    v0 = valid_cnt; e0 = err_cnt; p0 = pull_cnt;
  endtask

  initial begin
    m_scl = 1'b1;
    m_sda = 1'b1;
    i_rst = 1'b0;
    wait_h(4);
    check("rst_data", o_data, 16'h0000);
    check("rst_valid", 16'(o_valid), 16'd0);
    check("rst_busy", 16'(o_busy), 16'd0);
    check("rst_err", 16'(o_err), 16'd0);
    check("rst_sda", 16'(sda_bus), 16'd1);
    i_rst = 1'b1;
    wait_h(4 * H);

    // Normal frame
    snap();
    i2c_start();
    send_byte(8'h34, ack); check("t1_aack", 16'(ack), 16'd1);
    check("t1_busy_mid", 16'(o_busy), 16'd1);
    send_byte(8'h1E, ack); check("t1_dack1", 16'(ack), 16'd1);
    send_byte(8'h00, ack); check("t1_dack2", 16'(ack), 16'd1);
    i2c_stop();
    check("t1_valid", 16'(valid_cnt - v0), 16'd1);
    check("t1_data", o_data, 16'h1E00);
    check("t1_busy_end", 16'(o_busy), 16'd0);
    check("t1_err", 16'(err_cnt - e0), 16'd0);

    // Wrong address, then read bit
    snap();
    i2c_start();
    send_byte(8'h36, ack); check("t2_nack36", 16'(ack), 16'd0);
    i2c_stop();
    i2c_start();
    send_byte(8'h35, ack); check("t2_nack35", 16'(ack), 16'd0);
    i2c_stop();
    check("t2_pull", 16'(pull_cnt - p0), 16'd0);
    check("t2_valid", 16'(valid_cnt - v0), 16'd0);
    check("t2_err", 16'(err_cnt - e0), 16'd0);
    check("t2_data", o_data, 16'h1E00);

    // Truncated frame, then a full one
    snap();
    i2c_start();
    send_byte(8'h34, ack); check("t3_aack", 16'(ack), 16'd1);
    send_byte(8'h0E, ack); check("t3_dack1", 16'(ack), 16'd1);
    i2c_stop();
    check("t3_err", 16'(err_cnt - e0), 16'd1);
    check("t3_valid", 16'(valid_cnt - v0), 16'd0);
    check("t3_data_kept", o_data, 16'h1E00);
    snap();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h0A, ack);
    send_byte(8'h06, ack); check("t3b_dack2", 16'(ack), 16'd1);
    i2c_stop();
    check("t3b_data", o_data, 16'h0A06);
    check("t3b_valid", 16'(valid_cnt - v0), 16'd1);
    check("t3b_err", 16'(err_cnt - e0), 16'd0);

    // Repeated START after 4 bits of data byte 1
    snap();
    i2c_start();
    send_byte(8'h34, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    i2c_start();
    check("t4_err", 16'(err_cnt - e0), 16'd1);
    send_byte(8'h34, ack); check("t4_aack", 16'(ack), 16'd1);
    send_byte(8'h08, ack);
    send_byte(8'h12, ack);
    i2c_stop();
    check("t4_data", o_data, 16'h0812);
    check("t4_valid", 16'(valid_cnt - v0), 16'd1);
    check("t4_err_total", 16'(err_cnt - e0), 16'd1);

    // Fresh reset, then a frame with an extra data byte
    @(negedge i_clk) i_rst = 1'b0;
    wait_h(2);
    i_rst = 1'b1;
    wait_h(4 * H);
    snap();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h1E, ack);
    send_byte(8'h00, ack); check("t5_dack2", 16'(ack), 16'd1);
    send_byte(8'hFF, ack); check("t5_nack3", 16'(ack), 16'd0);
    i2c_stop();
    check("t5_valid", 16'(valid_cnt - v0), 16'd1);
    check("t5_data", o_data, 16'h1E00);
    check("t5_err", 16'(err_cnt - e0), 16'd1);
`ifdef I2C_TARGET_ERRCNT_EN
    check("t5_err_cnt", 16'(o_err_cnt), 16'd1);
`endif

    // Reset asserted while the address ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
    m_sda = 1'b1;
    wait_h(H);
    check("t6_ack_drv", 16'(sda_bus), 16'd0);
    i_rst = 1'b0;
    #1;
    check("t6_sda_rel", 16'(sda_bus), 16'd1);
    @(negedge i_clk);
    check("t6_data", o_data, 16'h0000);
    check("t6_busy", 16'(o_busy), 16'd0);
    check("t6_valid", 16'(o_valid), 16'd0);
    check("t6_err", 16'(o_err), 16'd0);
`ifdef I2C_TARGET_ERRCNT_EN
    check("t6_err_cnt", 16'(o_err_cnt), 16'd0);
`endif
    i_rst = 1'b1;
    wait_h(H);
    m_scl = 1'b1;
    wait_h(4 * H);
    snap();
    i2c_start();
    send_byte(8'h34, ack); check("t6b_aack", 16'(ack), 16'd1);
    send_byte(8'h0A, ack);
    send_byte(8'h06, ack);
    i2c_stop();
    check("t6b_data", o_data, 16'h0A06);
    check("t6b_valid", 16'(valid_cnt - v0), 16'd1);
    check("t6b_err", 16'(err_cnt - e0), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Write-only I2C target (slave) receiver, the far end of the codec-configuration I2C link driven by our 24-bit I2C sender. It samples SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs address and two data bytes, and presents each complete 16-bit register word on a one-cycle valid pulse. It is used as an on-chip configuration target and as a bus-accurate responder in the sender's testbench.

## Interface
- ADDR, 7'h1A, 7-bit target address; frame address byte 8'h34 = {ADDR, W}.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA; must be at least 2.
- i_clk  input  1  system clock; SCL/SDA oversampled on its rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_scl  input  1  bus clock (target never stretches).
- io_sda  inout  1  bus data, open-drain: driven 0 or 1'bz only, never 1.
- o_data  output  16  last accepted word {data byte 1, data byte 2}; held until next accept.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_busy  output  1  high from address-match ACK until STOP, error, or frame end.
- o_err  output  1  one-cycle pulse on a protocol error.

## Operation
- bus_sync sub-block: SYNC_STAGES flops per line plus one history flop. It produces scl_rise, scl_fall, start (SDA 1->0 while synced SCL high in current and previous sample), and stop (SDA 0->1 under the same SCL condition). An SCL edge and an SDA change in the same sample are a data edge, not START/STOP.
- States:
  - S_IDLE: wait for START.
  - S_ADDR: shift 8 bits, MSB first, sampled on scl_rise.
  - S_AACK: address ACK slot.
  - S_DATA: shift 8 bits.
  - S_DACK: data ACK slot.
  - S_WAIT: ignore the bus until START or STOP.
- Address byte complete: if byte == {ADDR,0}, go to S_AACK and set o_busy. Otherwise (wrong address or read bit) go to S_WAIT with no ACK and no o_err.
- ACK slot: assert SDA low on the scl_fall after the 8th bit. Release it on the scl_fall ending the ACK clock. Then go to S_DATA, or to S_WAIT after data byte 2.
- Data byte 1 is held in a register. After data byte 2 is sampled, update o_data and pulse o_valid.
- A third data byte gets no ACK: pulse o_err, enter S_WAIT.
- STOP in S_ADDR/S_AACK/S_DATA/S_DACK before o_valid: discard the partial frame, pulse o_err, go to S_IDLE. STOP after o_valid: go to S_IDLE with no error.
- START (repeated) in any state: clear the bit counter and shift register, release SDA, go to S_ADDR. If a frame was in progress (o_busy high, o_valid not yet given), also pulse o_err.
- Any state enters S_IDLE on STOP; o_busy clears on entry to S_IDLE or S_WAIT.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.

## Timing
- Reset values: o_data=16'h0000, o_valid=0, o_busy=0, o_err=0, SDA released (Z), state S_IDLE, counters 0.
- Reset mid-frame releases SDA immediately, because the reset is asynchronous.
- Edge and START/STOP events appear SYNC_STAGES+1 cycles after the pin transition at i_clk.
- Every state action takes effect on the clock after its event; an SCL high of a single i_clk cycle is sufficient.
- SDA pull-low begins 1 cycle after the qualifying scl_fall event; release likewise 1 cycle after its scl_fall event.
- o_valid is asserted 1 cycle after the scl_rise event of data byte 2, bit 0, together with the new o_data. The ACK for byte 2 follows.
- o_err is a single-cycle pulse, 1 cycle after the triggering START/STOP/rise event.

## Configuration
- I2C_TARGET_ERRCNT_EN defined:
  - Adds output o_err_cnt [7:0], reset 0.
  - Increments on every o_err pulse and saturates at 8'hFF.
  - Address mismatch does not count.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package i2c_pkg holds:
  - the state enum for S_IDLE..S_WAIT;
  - the codec address constant 7'h1A;
  - localparam FRAME_DATA_BYTES = 2;
  - the address-byte helper constant {ADDR, 1'b0}.
- Sub-module i2c_bus_sync: synchronizer, history flop, and scl_rise/scl_fall/start/stop generation.
- Top level holds the FSM, shift register, ACK driver and outputs.

## Test plan
- The bench models the bus as a pull-up wired-AND.
- Frame 0x34,0x1E,0x00 then STOP -> three ACKs, one o_valid with o_data=16'h1E00, o_busy low after STOP, o_err never.
- Address 0x36, and separately 0x35 (read) -> SDA never pulled low, no o_valid, no o_err, o_data unchanged.
- 0x34,0x0E then STOP -> two ACKs, o_err pulse, no o_valid; the next full frame 0x34,0x0A,0x06 gives o_data=16'h0A06.
- Repeated START after 4 bits of data byte 1, then 0x34,0x08,0x12 -> o_err pulse, then o_valid with 16'h0812.
- 0x34,0x1E,0x00,0xFF -> o_valid (16'h1E00), fourth byte not ACKed, o_err pulse.
  - With I2C_TARGET_ERRCNT_EN, o_err_cnt=1.
- i_rst low during the address ACK -> SDA Z immediately, all outputs 0; a following full frame is accepted normally.
